// File: rtl/mdu_pkg.sv
// Multiply/divide unit shared types: op codes, FSM states, arithmetic helpers.
// Signed math works on magnitudes, so INT_MIN / -1 wraps cleanly instead of trapping.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic [63:0] md_mul(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sgn
  );
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {{32{sgn & a[31]}}, a};
    bx = {{32{sgn & b[31]}}, b};
    return ax * bx;
  endfunction

  // Returns {remainder, quotient}; divisor 0 yields 0 (caller skips commit).
  function automatic logic [63:0] md_div(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sgn
  );
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    logic        na;
    logic        nb;
    na = sgn & a[31];
    nb = sgn & b[31];
    ua = na ? -a : a;
    ub = nb ? -b : b;
    if (ub == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    return {(na ? -r : r), ((na ^ nb) ? -q : q)};
  endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage <-> MDU bundle: issue request and operands in, HI/LO and busy out.
interface mdu_if;
  logic [2:0]  md_op;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  modport master (
    output md_op, RD1, RD2, flush,
    input  hi, lo, busy
  );

  modport slave (
    input  md_op, RD1, RD2, flush,
    output hi, lo, busy
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO; result is computed at issue
// and held in a pending register until the busy countdown commits it.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int unsigned MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW = $clog2(MAXC + 1);

  mdu_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [31:0]   phi_q;
  logic [31:0]   plo_q;
  logic          pwr_q;
  logic          busy_q;

  md_op_e      op;
  logic        issue;
  logic        is_mul;
  logic        is_div;
  logic        is_mthi;
  logic [63:0] mul_r;
  logic [63:0] div_r;

  assign op      = md_op_e'(bus.md_op);
  assign issue   = (state_q == S_IDLE) && !bus.flush
                && (op != MD_NONE) && (op != MD_RSVD);
  assign is_mul  = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div  = (op == MD_DIV) || (op == MD_DIVU);
  assign is_mthi = (op == MD_MTHI);
  assign mul_r   = md_mul(bus.RD1, bus.RD2, op == MD_MULT);
  assign div_r   = md_div(bus.RD1, bus.RD2, op == MD_DIV);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (issue) begin
            unique case (1'b1)
              is_mul: begin
                {phi_q, plo_q} <= mul_r;
                pwr_q   <= 1'b1;
                cnt_q   <= CW'(MULT_CYCLES);
                busy_q  <= 1'b1;
                state_q <= S_RUN;
              end
              is_div: begin
                {phi_q, plo_q} <= div_r;
                pwr_q   <= (bus.RD2 != 32'd0);
                cnt_q   <= CW'(DIV_CYCLES);
                busy_q  <= 1'b1;
                state_q <= S_RUN;
              end
              is_mthi: hi_q <= bus.RD1;
              default: lo_q <= bus.RD1;
            endcase
          end
        end
        S_RUN: begin
          if (cnt_q == CW'(1)) begin
            if (pwr_q) begin
              hi_q <= phi_q;
              lo_q <= plo_q;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;

endmodule
